// File: rtl/program_loader_if.sv
// Program loader bus: UART byte stream in, ack byte out,
// instruction BRAM write port and load status.
interface program_loader_if #(
    parameter int ADDR_W = 14
);
    logic [2:0]        mode;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   words_done;
    logic              done;
    logic              error;

    modport master (
        input  mode, rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data,
        output mem_we, mem_addr, mem_wdata,
        output words_done, done, error
    );

    modport slave (
        output mode, rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data,
        input  mem_we, mem_addr, mem_wdata,
        input  words_done, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: header word count N, then N little-endian
// words written to instruction BRAM, then one ack byte.
module program_loader #(
    parameter int          ADDR_W   = 14,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic             clk,
    input  logic             rstn,
    program_loader_if.master bus
);
    localparam logic [2:0]  S_HDR  = 3'd0;
    localparam logic [2:0]  S_DATA = 3'd1;
    localparam logic [2:0]  S_ACK  = 3'd2;
    localparam logic [2:0]  S_FIN  = 3'd3;
    localparam logic [2:0]  S_ERR  = 3'd4;
    localparam logic [2:0]  M_LOAD = 3'd1;
    localparam logic [32:0] MAX_N  = 33'd1 << ADDR_W;

    logic [2:0]        r_state;
    logic [1:0]        r_idx;
    logic [23:0]       r_word;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_words_done;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_done;
    logic              r_error;

    logic              w_load;
    logic              w_accept;
    logic              w_last_byte;
    logic [31:0]       w_full;
    logic [ADDR_W:0]   w_words_next;
    logic              w_hdr_zero;
    logic              w_hdr_big;

    assign w_load       = (bus.mode == M_LOAD);
    assign w_accept     = bus.rx_valid && w_load &&
                          ((r_state == S_HDR) || (r_state == S_DATA));
    assign w_last_byte  = w_accept && (r_idx == 2'd3);
    assign w_full       = {bus.rx_data, r_word};
    assign w_words_next = r_words_done + 1'b1;
    assign w_hdr_zero   = (w_full == 32'd0);
    assign w_hdr_big    = ({1'b0, w_full} > MAX_N);

    // Byte index and the three low bytes of the word being built.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx  <= 2'd0;
            r_word <= 24'd0;
        end else if (w_accept) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_word[7:0]   <= bus.rx_data;
                2'd1:    r_word[15:8]  <= bus.rx_data;
                2'd2:    r_word[23:16] <= bus.rx_data;
                default: r_word        <= r_word;
            endcase
        end
    end

    // Load sequencing: header decode, BRAM writes, ack handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_HDR;
            r_n          <= '0;
            r_words_done <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            // A write issued last cycle retires here, even if mode
            // has just left LOAD, so mem_we stays a single pulse.
            if (r_mem_we) begin
                r_words_done <= w_words_next;
                if (w_words_next == r_n) begin
                    r_state    <= S_ACK;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= ACK_BYTE;
                end
            end
            case (r_state)
                S_HDR: begin
                    if (w_last_byte) begin
                        if (w_hdr_zero) begin
                            r_state    <= S_ACK;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= ACK_BYTE;
                        end else if (w_hdr_big) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_n     <= w_full[ADDR_W:0];
                        end
                    end
                end
                S_DATA: begin
                    if (w_last_byte) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_words_done[ADDR_W-1:0];
                        r_mem_wdata <= w_full;
                    end
                end
                S_ACK: begin
                    if (w_load && bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_FIN;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bus.tx_valid   = r_tx_valid;
    assign bus.tx_data    = r_tx_data;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.words_done = r_words_done;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed images, scoreboard queues
// for BRAM writes and ack bytes, checked by a negedge monitor.
module tb_program_loader;
    localparam int AW = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(
        .ADDR_W   (AW),
        .ACK_BYTE (8'hAA)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    wr_t        m_e;
    logic [7:0] m_b;
    int         n_cmp = 0;
    int         n_err = 0;

    // Monitor: every BRAM write and every ack handshake is popped
    // against what the stimulus side queued.
    always @(negedge clk) begin
        if (rstn && bus.mem_we) begin
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0h data %08h, required none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                m_e = exp_wr.pop_front();
                if (bus.mem_addr !== m_e.addr || bus.mem_wdata !== m_e.data) begin
                    n_err++;
                    $display("FAIL mem_write: got addr %0h data %08h, required addr %0h data %08h",
                             bus.mem_addr, bus.mem_wdata, m_e.addr, m_e.data);
                end
            end
        end
        if (rstn && bus.tx_valid && bus.tx_ready && bus.mode == 3'd1) begin
            n_cmp++;
            if (exp_tx.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tx: byte %02h, required none", bus.tx_data);
            end else begin
                m_b = exp_tx.pop_front();
                if (bus.tx_data !== m_b) begin
                    n_err++;
                    $display("FAIL tx_byte: got %02h, required %02h", bus.tx_data, m_b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = a[AW-1:0];
        e.data = d;
        exp_wr.push_back(e);
    endtask

    // Pulls reset low mid-cycle and checks outputs clear before any edge.
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_tx_valid",   bus.tx_valid,   0);
        chk("rst_tx_data",    bus.tx_data,    0);
        chk("rst_mem_we",     bus.mem_we,     0);
        chk("rst_mem_addr",   bus.mem_addr,   0);
        chk("rst_mem_wdata",  bus.mem_wdata,  0);
        chk("rst_words_done", bus.words_done, 0);
        chk("rst_done",       bus.done,       0);
        chk("rst_error",      bus.error,      0);
        tick();
        rstn = 1'b1;
    endtask

    task automatic wait_tx();
        int k = 0;
        while (!bus.tx_valid && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!bus.tx_valid) begin
            n_err++;
            $display("FAIL tx_timeout: tx_valid 0 after %0d cycles, required 1", k);
        end
    endtask

    task automatic ack_handshake();
        exp_tx.push_back(8'hAA);
        wait_tx();
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("fin_done",     bus.done,     1);
        chk("fin_tx_valid", bus.tx_valid, 0);
    endtask

    initial begin
        bus.mode     = 3'd1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.tx_ready = 1'b0;
        do_reset();

        // Two-word image.
        push_wr(0, 32'h11223344);
        push_wr(1, 32'hAABBCCDD);
        send_word(32'd2);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        wait_tx();
        chk("img2_words_done", bus.words_done, 2);
        chk("img2_tx_data",    bus.tx_data,    8'hAA);
        chk("img2_done_early", bus.done,       0);
        ack_handshake();
        send_byte(8'h55);
        repeat (3) tick();
        chk("fin_ignores_rx", bus.words_done, 2);

        // Empty image, ack held off for 10 cycles.
        do_reset();
        send_word(32'd0);
        chk("n0_tx_immediate", bus.tx_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("n0_tx_valid_hold", bus.tx_valid, 1);
            chk("n0_tx_data_hold",  bus.tx_data,  8'hAA);
        end
        chk("n0_not_done", bus.done, 0);
        ack_handshake();
        chk("n0_words_done", bus.words_done, 0);

        // Oversized count: error, no writes, no ack.
        do_reset();
        bus.tx_ready = 1'b1;
        send_word(32'd17);
        chk("err_flag", bus.error, 1);
        send_word(32'h01020304);
        repeat (5) tick();
        chk("err_no_tx",   bus.tx_valid,   0);
        chk("err_no_done", bus.done,       0);
        chk("err_hold",    bus.error,      1);
        chk("err_words",   bus.words_done, 0);
        bus.tx_ready = 1'b0;

        // Exactly full memory.
        do_reset();
        send_word(32'd16);
        for (int i = 0; i < 16; i++) begin
            push_wr(i, 32'hDEAD0000 ^ (32'h01010101 * i));
            send_word(32'hDEAD0000 ^ (32'h01010101 * i));
        end
        wait_tx();
        chk("full_words_done", bus.words_done, 16);
        chk("full_last_addr",  bus.mem_addr,   4'hF);
        chk("full_error",      bus.error,      0);
        ack_handshake();

        // Stall mid-word with dropped bytes.
        do_reset();
        send_word(32'd1);
        push_wr(0, 32'hCAFEF00D);
        send_byte(8'h0D);
        send_byte(8'hF0);
        bus.mode = 3'd0;
        send_byte(8'hEE);
        send_byte(8'hEE);
        send_byte(8'hEE);
        chk("stall_words", bus.words_done, 0);
        bus.mode = 3'd1;
        send_byte(8'hFE);
        send_byte(8'hCA);
        ack_handshake();
        chk("stall_words_after", bus.words_done, 1);

        // Reset in the middle of the second word, then a fresh image.
        do_reset();
        send_word(32'd2);
        push_wr(0, 32'h0BADBEEF);
        send_word(32'h0BADBEEF);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("pre_rst_words", bus.words_done, 1);
        do_reset();
        push_wr(0, 32'h5A5AA5A5);
        send_word(32'd1);
        send_word(32'h5A5AA5A5);
        ack_handshake();
        chk("rst_reload_words", bus.words_done, 1);

        repeat (3) tick();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
